// File: rtl/vc_store_pkg.sv
// ---------------------------------------------------------------------------
// lc3b_types: types and default constants for the victim-cache store.
//   VC_WIDTH / VC_DEPTH / VC_TAG_W : default line width, entry count, tag width
//   vc_idx_t : entry index for the default depth
//   vc_age_t : per-entry LRU age for the default depth (0 = MRU)
// Modules built at a non-default DEPTH size their internal index/age vectors
// from their own DEPTH parameter.
// ---------------------------------------------------------------------------
package lc3b_types;

  localparam int VC_WIDTH = 128;
  localparam int VC_DEPTH = 8;
  localparam int VC_TAG_W = 12;

  typedef logic [$clog2(VC_DEPTH)-1:0] vc_idx_t;
  typedef logic [$clog2(VC_DEPTH)-1:0] vc_age_t;

endpackage

// File: rtl/vc_store_lru.sv
// ---------------------------------------------------------------------------
// vc_lru: age bookkeeping for the victim-cache store.
// Each entry carries an age; the ages always form a permutation of
// 0..DEPTH-1. A touch moves the touched entry to age 0 and shifts every
// younger entry one step older, which preserves the permutation.
//   clk, reset_n : clock, synchronous active-low reset (ages -> identity)
//   touch        : apply a touch this cycle
//   touch_idx    : entry being touched
//   lru_idx      : entry currently holding age DEPTH-1
// ---------------------------------------------------------------------------
module vc_lru
  import lc3b_types::*;
#(
  parameter int  DEPTH = VC_DEPTH,
  localparam int IW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          touch,
  input  logic [IW-1:0] touch_idx,
  output logic [IW-1:0] lru_idx
);

  logic [IW-1:0] age [DEPTH];

  // NOTE: state registers are assigned with <= so every entry sees the
  // pre-edge ages, independent of loop or statement order.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) age[i] <= IW'(i);
    end else if (touch) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (IW'(i) == touch_idx)          age[i] <= '0;
        else if (age[i] < age[touch_idx]) age[i] <= age[i] + 1'b1;
      end
    end
  end

  // NOTE: default assignment first so no path leaves lru_idx unassigned
  // (otherwise a latch is inferred).
  always_comb begin
    lru_idx = '0;
    for (int i = 0; i < DEPTH; i++)
      if (age[i] == IW'(DEPTH - 1)) lru_idx = IW'(i);
  end

endmodule

// File: rtl/vc_store.sv
// ---------------------------------------------------------------------------
// vc_store: fully associative victim-cache storage with true-LRU replacement.
//   clk, reset_n          : clock, synchronous active-low reset
//   lookup/lookup_tag     : search request; lookup_take removes a hit entry
//   insert/insert_*       : line to insert (in-place overwrite on tag match)
//   hit, hit_data/dirty   : registered lookup result (1-cycle latency)
//   evict, evict_*        : one-cycle pulse with the displaced entry
//   count, full, empty    : registered post-edge occupancy
// ---------------------------------------------------------------------------
module vc_store
  import lc3b_types::*;
#(
  parameter int  WIDTH = VC_WIDTH,
  parameter int  DEPTH = VC_DEPTH,
  parameter int  TAG_W = VC_TAG_W,
  localparam int IW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             lookup,
  input  logic [TAG_W-1:0] lookup_tag,
  input  logic             lookup_take,
  input  logic             insert,
  input  logic [TAG_W-1:0] insert_tag,
  input  logic [WIDTH-1:0] insert_data,
  input  logic             insert_dirty,
  output logic             hit,
  output logic [WIDTH-1:0] hit_data,
  output logic             hit_dirty,
  output logic             evict,
  output logic [TAG_W-1:0] evict_tag,
  output logic [WIDTH-1:0] evict_data,
  output logic             evict_dirty,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [DEPTH-1:0] valid, dirty, valid_eff;
  logic [TAG_W-1:0] tags [DEPTH];
  logic [WIDTH-1:0] data [DEPTH];

  logic          look_hit, take, ins_hit, free_any, do_evict, grow, touch;
  logic [IW-1:0] look_idx, ins_idx, free_idx, tgt, touch_idx, lru_idx;
  logic [CW-1:0] count_next;

  always_comb begin
    look_hit = 1'b0;
    look_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--)
      if (valid[i] && tags[i] == lookup_tag) begin
        look_hit = 1'b1;
        look_idx = IW'(i);
      end
    take = lookup && look_hit && lookup_take;

    // A taken entry is freed before the insert picks its slot.
    valid_eff = valid;
    if (take) valid_eff[look_idx] = 1'b0;

    ins_hit  = 1'b0;
    ins_idx  = '0;
    free_any = 1'b0;
    free_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (valid_eff[i] && tags[i] == insert_tag) begin
        ins_hit = 1'b1;
        ins_idx = IW'(i);
      end
      if (!valid_eff[i]) begin
        free_any = 1'b1;
        free_idx = IW'(i);
      end
    end

    if (ins_hit)       tgt = ins_idx;
    else if (free_any) tgt = free_idx;
    else               tgt = lru_idx;

    do_evict = insert && !ins_hit && !free_any;
    grow     = insert && !ins_hit && free_any;

    // The insert touch wins over a same-cycle lookup touch.
    touch     = insert || (lookup && look_hit && !lookup_take);
    touch_idx = insert ? tgt : look_idx;

    count_next = count + CW'(grow) - CW'(take);
  end

  vc_lru #(.DEPTH(DEPTH)) u_lru (
    .clk       (clk),
    .reset_n   (reset_n),
    .touch     (touch),
    .touch_idx (touch_idx),
    .lru_idx   (lru_idx)
  );

  // NOTE: tag and data arrays are deliberately not reset; valid bits gate
  // every use, and leaving them unreset lets them map onto plain storage.
  always_ff @(posedge clk) begin
    if (reset_n && insert) begin
      tags[tgt] <= insert_tag;
      data[tgt] <= insert_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      valid       <= '0;
      dirty       <= '0;
      hit         <= 1'b0;
      hit_data    <= '0;
      hit_dirty   <= 1'b0;
      evict       <= 1'b0;
      evict_tag   <= '0;
      evict_data  <= '0;
      evict_dirty <= 1'b0;
      count       <= '0;
      full        <= 1'b0;
      empty       <= 1'b1;
    end else begin
      if (take) valid[look_idx] <= 1'b0;
      // Later assignment wins when the insert reuses the slot just taken.
      if (insert) begin
        valid[tgt] <= 1'b1;
        dirty[tgt] <= insert_dirty;
      end

      hit <= lookup && look_hit;
      if (lookup && look_hit) begin
        hit_data  <= data[look_idx];
        hit_dirty <= dirty[look_idx];
      end

      evict <= do_evict;
      if (do_evict) begin
        evict_tag   <= tags[tgt];
        evict_data  <= data[tgt];
        evict_dirty <= dirty[tgt];
      end

      count <= count_next;
      full  <= (count_next == CW'(DEPTH));
      empty <= (count_next == '0);
    end
  end

endmodule

// File: tb/tb_vc_store.sv
// ---------------------------------------------------------------------------
// tb_vc_store: directed, table-driven bench for vc_store (DEPTH 8), with
// DEPTH 4 and DEPTH 16 instances sharing the stimulus for the reset cases.
// ---------------------------------------------------------------------------
module tb_vc_store;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         lookup, lookup_take, insert, insert_dirty;
  logic [11:0]  lookup_tag, insert_tag;
  logic [127:0] insert_data;

  logic         hit8, hdirty8, ev8, edirty8, full8, empty8;
  logic [127:0] hdata8, edata8;
  logic [11:0]  etag8;
  logic [3:0]   count8;

  logic         hit4, hdirty4, ev4, edirty4, full4, empty4;
  logic [127:0] hdata4, edata4;
  logic [11:0]  etag4;
  logic [2:0]   count4;

  logic         hit16, hdirty16, ev16, edirty16, full16, empty16;
  logic [127:0] hdata16, edata16;
  logic [11:0]  etag16;
  logic [4:0]   count16;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  vc_store #(.DEPTH(8)) u8 (
    .clk(clk), .reset_n(reset_n), .lookup(lookup), .lookup_tag(lookup_tag),
    .lookup_take(lookup_take), .insert(insert), .insert_tag(insert_tag),
    .insert_data(insert_data), .insert_dirty(insert_dirty),
    .hit(hit8), .hit_data(hdata8), .hit_dirty(hdirty8),
    .evict(ev8), .evict_tag(etag8), .evict_data(edata8), .evict_dirty(edirty8),
    .count(count8), .full(full8), .empty(empty8));

  vc_store #(.DEPTH(4)) u4 (
    .clk(clk), .reset_n(reset_n), .lookup(lookup), .lookup_tag(lookup_tag),
    .lookup_take(lookup_take), .insert(insert), .insert_tag(insert_tag),
    .insert_data(insert_data), .insert_dirty(insert_dirty),
    .hit(hit4), .hit_data(hdata4), .hit_dirty(hdirty4),
    .evict(ev4), .evict_tag(etag4), .evict_data(edata4), .evict_dirty(edirty4),
    .count(count4), .full(full4), .empty(empty4));

  vc_store #(.DEPTH(16)) u16 (
    .clk(clk), .reset_n(reset_n), .lookup(lookup), .lookup_tag(lookup_tag),
    .lookup_take(lookup_take), .insert(insert), .insert_tag(insert_tag),
    .insert_data(insert_data), .insert_dirty(insert_dirty),
    .hit(hit16), .hit_data(hdata16), .hit_dirty(hdirty16),
    .evict(ev16), .evict_tag(etag16), .evict_data(edata16), .evict_dirty(edirty16),
    .count(count16), .full(full16), .empty(empty16));

  typedef struct {
    logic         lk, tk;
    logic [11:0]  ltag;
    logic         ins;
    logic [11:0]  itag;
    logic [127:0] idata;
    logic         idirty;
    logic         e_hit;
    logic [127:0] e_hdata;
    logic         e_hdirty;
    logic         e_ev;
    logic [11:0]  e_etag;
    logic [127:0] e_edata;
    logic         e_edirty;
    logic [3:0]   e_cnt;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs [NV];

  function automatic logic [127:0] line(input logic [11:0] t);
    return {8{4'hA, t}};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    lookup = 1'b0; lookup_take = 1'b0; lookup_tag = '0;
    insert = 1'b0; insert_tag = '0; insert_data = '0; insert_dirty = 1'b0;
  endtask

  initial begin
    logic [11:0] t;
    reset_n = 1'b0;
    idle_inputs();

    // Fill 0x001..0x008 into an empty store: odd tags are dirty.
    for (int i = 0; i < 8; i++) begin
      t = 12'(i + 1);
      vecs[i] = '{1'b0, 1'b0, 12'h0, 1'b1, t, line(t), t[0],
                  1'b0, 128'h0, 1'b0, 1'b0, 12'h0, 128'h0, 1'b0, 4'(i + 1)};
    end
    // lookup 0x003 (no take) -> hit, 0x003 becomes MRU
    vecs[8]  = '{1'b1, 1'b0, 12'h003, 1'b0, 12'h0, 128'h0, 1'b0,
                 1'b1, line(12'h003), 1'b1, 1'b0, 12'h0, 128'h0, 1'b0, 4'd8};
    // insert 0x009 into full store -> evicts LRU 0x001
    vecs[9]  = '{1'b0, 1'b0, 12'h0, 1'b1, 12'h009, line(12'h009), 1'b1,
                 1'b0, 128'h0, 1'b0, 1'b1, 12'h001, line(12'h001), 1'b1, 4'd8};
    // take 0x005 and insert 0x00A together -> hit, no evict, count holds
    vecs[10] = '{1'b1, 1'b1, 12'h005, 1'b1, 12'h00A, line(12'h00A), 1'b0,
                 1'b1, line(12'h005), 1'b1, 1'b0, 12'h0, 128'h0, 1'b0, 4'd8};
    vecs[11] = '{1'b1, 1'b0, 12'h00A, 1'b0, 12'h0, 128'h0, 1'b0,
                 1'b1, line(12'h00A), 1'b0, 1'b0, 12'h0, 128'h0, 1'b0, 4'd8};
    vecs[12] = '{1'b1, 1'b0, 12'h005, 1'b0, 12'h0, 128'h0, 1'b0,
                 1'b0, 128'h0, 1'b0, 1'b0, 12'h0, 128'h0, 1'b0, 4'd8};
    // overwrite 0x004 in place with new data, dirty
    vecs[13] = '{1'b0, 1'b0, 12'h0, 1'b1, 12'h004, ~line(12'h004), 1'b1,
                 1'b0, 128'h0, 1'b0, 1'b0, 12'h0, 128'h0, 1'b0, 4'd8};
    vecs[14] = '{1'b1, 1'b0, 12'h004, 1'b0, 12'h0, 128'h0, 1'b0,
                 1'b1, ~line(12'h004), 1'b1, 1'b0, 12'h0, 128'h0, 1'b0, 4'd8};
    // idle cycle -> hit drops
    vecs[15] = '{1'b0, 1'b0, 12'h0, 1'b0, 12'h0, 128'h0, 1'b0,
                 1'b0, 128'h0, 1'b0, 1'b0, 12'h0, 128'h0, 1'b0, 4'd8};
    // absent tag
    vecs[16] = '{1'b1, 1'b0, 12'h0FF, 1'b0, 12'h0, 128'h0, 1'b0,
                 1'b0, 128'h0, 1'b0, 1'b0, 12'h0, 128'h0, 1'b0, 4'd8};
    // insert 0x00B -> LRU is now 0x002 (clean)
    vecs[17] = '{1'b0, 1'b0, 12'h0, 1'b1, 12'h00B, line(12'h00B), 1'b1,
                 1'b0, 128'h0, 1'b0, 1'b1, 12'h002, line(12'h002), 1'b0, 4'd8};

    // Reset state
    step(); step();
    check("rst_hit", 128'(hit8), 128'(0));
    check("rst_evict", 128'(ev8), 128'(0));
    check("rst_count", 128'(count8), 128'(0));
    check("rst_empty", 128'(empty8), 128'(1));
    check("rst_full", 128'(full8), 128'(0));
    check("rst_hit_data", hdata8, 128'(0));
    check("rst_evict_data", edata8, 128'(0));
    reset_n = 1'b1;

    // take on an empty store
    lookup = 1'b1; lookup_take = 1'b1; lookup_tag = 12'h003;
    step();
    idle_inputs();
    check("empty_take_hit", 128'(hit8), 128'(0));
    check("empty_take_count", 128'(count8), 128'(0));
    check("empty_take_empty", 128'(empty8), 128'(1));

    for (int i = 0; i < NV; i++) begin
      lookup = vecs[i].lk; lookup_take = vecs[i].tk; lookup_tag = vecs[i].ltag;
      insert = vecs[i].ins; insert_tag = vecs[i].itag;
      insert_data = vecs[i].idata; insert_dirty = vecs[i].idirty;
      step();
      check($sformatf("v%0d_hit", i), 128'(hit8), 128'(vecs[i].e_hit));
      if (vecs[i].e_hit) begin
        check($sformatf("v%0d_hit_data", i), hdata8, vecs[i].e_hdata);
        check($sformatf("v%0d_hit_dirty", i), 128'(hdirty8), 128'(vecs[i].e_hdirty));
      end
      check($sformatf("v%0d_evict", i), 128'(ev8), 128'(vecs[i].e_ev));
      if (vecs[i].e_ev) begin
        check($sformatf("v%0d_evict_tag", i), 128'(etag8), 128'(vecs[i].e_etag));
        check($sformatf("v%0d_evict_data", i), edata8, vecs[i].e_edata);
        check($sformatf("v%0d_evict_dirty", i), 128'(edirty8), 128'(vecs[i].e_edirty));
      end
      check($sformatf("v%0d_count", i), 128'(count8), 128'(vecs[i].e_cnt));
      check($sformatf("v%0d_full", i), 128'(full8), 128'(vecs[i].e_cnt == 4'd8));
      check($sformatf("v%0d_empty", i), 128'(empty8), 128'(vecs[i].e_cnt == 4'd0));
    end
    idle_inputs();

    // Reset during insert to a full store, all three depths
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      insert = 1'b1; insert_tag = 12'(12'h101 + i);
      insert_data = line(insert_tag); insert_dirty = 1'b1;
      step();
    end
    check("fill16_full", 128'(full16), 128'(1));
    check("fill16_count", 128'(count16), 128'(16));
    check("fill8_full", 128'(full8), 128'(1));
    check("fill4_full", 128'(full4), 128'(1));

    reset_n = 1'b0;
    insert = 1'b1; insert_tag = 12'h111; insert_data = line(12'h111);
    lookup = 1'b1; lookup_tag = 12'h110;
    step();
    check("rsti_evict8", 128'(ev8), 128'(0));
    check("rsti_evict4", 128'(ev4), 128'(0));
    check("rsti_evict16", 128'(ev16), 128'(0));
    check("rsti_hit16", 128'(hit16), 128'(0));
    check("rsti_count8", 128'(count8), 128'(0));
    check("rsti_count4", 128'(count4), 128'(0));
    check("rsti_count16", 128'(count16), 128'(0));
    check("rsti_empty8", 128'(empty8), 128'(1));
    check("rsti_empty4", 128'(empty4), 128'(1));
    check("rsti_empty16", 128'(empty16), 128'(1));
    check("rsti_full8", 128'(full8), 128'(0));

    reset_n = 1'b1;
    idle_inputs();
    step();
    check("post_evict8", 128'(ev8), 128'(0));
    check("post_evict4", 128'(ev4), 128'(0));
    check("post_hit8", 128'(hit8), 128'(0));
    check("post_count8", 128'(count8), 128'(0));
    check("post_count16", 128'(count16), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/vc_store.md
VC_STORE -- requirements
Module: vc_store

Interface
REQ-001 Parameter WIDTH, default 128: data bits per entry (one cache line).
REQ-002 Parameter DEPTH, default 8: entry count; power of two, 2..32.
REQ-003 Parameter TAG_W, default 12: tag bits per entry.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 reset_n  in  1  reset, synchronous and active-low.
REQ-006 lookup  in  1  lookup request this cycle.
REQ-007 lookup_tag  in  TAG_W  tag to search.
REQ-008 lookup_take  in  1  on hit, remove the hit entry (swap-out to L1).
REQ-009 insert  in  1  insert request this cycle.
REQ-010 insert_tag / insert_data / insert_dirty  in  TAG_W / WIDTH / 1  line being inserted.
REQ-011 hit  out  1  registered lookup result.
REQ-012 hit_data / hit_dirty  out  WIDTH / 1  contents of the hit entry.
REQ-013 evict  out  1  one-cycle pulse: an entry was displaced.
REQ-014 evict_tag / evict_data / evict_dirty  out  TAG_W / WIDTH / 1  displaced entry.
REQ-015 count  out  $clog2(DEPTH)+1  number of valid entries; full and empty  out  1 each.

Function
REQ-016 Each entry SHALL hold valid, dirty, tag and data, plus an age value (0 = MRU, DEPTH-1 = LRU); the ages SHALL always form a permutation of 0..DEPTH-1.
REQ-017 A lookup in cycle N SHALL search all valid entries using pre-edge contents, and SHALL present hit, hit_data and hit_dirty in cycle N+1 (1-cycle latency); outputs hold until the next lookup; hit SHALL be 0 in the cycle after any cycle with lookup=0.
REQ-018 On a lookup hit with lookup_take=0, the hit entry SHALL become MRU; with lookup_take=1, its valid bit SHALL clear at the edge and the ages SHALL remain unchanged.
REQ-019 Touch rule: every entry with age below the touched entry's age SHALL increment, and the touched entry SHALL be set to 0.
REQ-020 An insert whose tag matches a valid entry SHALL overwrite that entry in place (data, dirty), touch it, and SHALL NOT evict.
REQ-021 Otherwise, an insert SHALL use the lowest-index invalid entry; if none is invalid, it SHALL use the entry with age DEPTH-1, and evict SHALL pulse in cycle N+1 with that entry's old tag, data and dirty.
REQ-022 An insert into an entry with valid=0 SHALL NOT pulse evict, and the target entry SHALL be touched.
REQ-023 Same-cycle lookup_take hit and insert: the removal SHALL be applied first, so that the freed slot is eligible, and the insert SHALL NOT evict.
REQ-024 Same-cycle lookup (no take) and insert with equal tags: the lookup SHALL report pre-edge state; the insert touch SHALL take precedence over the hit touch.
REQ-025 count, full (count==DEPTH) and empty (count==0) SHALL reflect post-edge state and be registered.
REQ-026 evict and hit payload outputs SHALL be don't-care when their qualifier is 0, but SHALL NOT contain X after reset.

Reset
REQ-027 When reset_n=0 at an edge, reset SHALL clear all valid and dirty bits, set age[i]=i, and drive hit=0, evict=0, count=0, empty=1 and full=0.
REQ-028 Reset SHALL NOT clear entry data or tags; all payload outputs SHALL be driven to 0.
REQ-029 A reset asserted in the same cycle as an insert or lookup SHALL win; the request SHALL be dropped, with no evict and no hit afterwards.

Structure
REQ-030 The shared package (lc3b_types) SHALL hold the vc_age_t and vc_idx_t typedefs, sized from DEPTH, and the default WIDTH, DEPTH and TAG_W constants.
REQ-031 The age/LRU bookkeeping SHALL be one sub-module, vc_lru (touch index in, LRU index out, reset to identity).
REQ-032 The implementation SHALL have no latches, and the data array SHALL be a register array written with non-blocking assignments.

Verification
REQ-033 Reset, then 8 inserts of tags 0x001..0x008 -> count=8, full=1, no evict pulse, tag 0x001 age 7.
REQ-034 From REQ-033, lookup 0x003 (no take), then insert 0x009 -> hit=1 next cycle with data of 0x003; the insert evicts 0x001.
REQ-035 From full, lookup_take 0x005 and insert 0x00A in the same cycle -> hit=1, evict=0, count stays 8, and 0x00A occupies 0x005's slot.
REQ-036 Insert 0x004 with new data while 0x004 is valid -> no evict, count unchanged, and a later lookup returns the new data and dirty.
REQ-037 Lookup 0x0FF (absent) -> hit=0; lookup_take on an empty store -> hit=0 and count stays 0.
REQ-038 Assert reset_n=0 during an insert to a full store -> no evict pulse, count=0 and empty=1 on the next cycle; repeat with DEPTH=4 and DEPTH=16.
